// File: rtl/sw_irq_servicer.sv
// sw_irq_servicer
// Services interrupts from a switch PIO. After reset it writes the irq_mask
// once. Then, on each interrupt, it reads and clears edge_capture, reads the
// switch levels, and queues {edges, levels} in a small show-ahead FIFO for a
// consumer.
//
// Ports
//   clk, reset       sole clock; synchronous active-high reset
//   enable           service interrupts while high; a running sequence always completes
//   irq              interrupt request from the switch PIO
//   m_address, m_chipselect, m_write_n, m_writedata
//                    PIO register access (0 data, 2 irq_mask, 3 edge_capture)
//   m_readdata       PIO read data, valid one cycle after the address is driven
//   ev_valid, ev_ready, ev_edges, ev_level
//                    event queue head and pop handshake
//   ev_overflow, ev_overflow_clr
//                    sticky drop flag and its clear
module sw_irq_servicer #(
  parameter int               WIDTH      = 18,
  parameter logic [WIDTH-1:0] MASK_INIT  = 18'h3FFFF,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             irq,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [WIDTH-1:0] ev_edges,
  output logic [WIDTH-1:0] ev_level,
  output logic             ev_overflow,
  input  logic             ev_overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    INIT, IDLE, RD_CAP, CAP_WAIT, CLR, RD_DATA, DATA_WAIT, PUSH
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] cap, lvl;
  logic [WIDTH-1:0] fifo_edges [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_level [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             empty, full, pop, push, drop, overflow;

  // Only WIDTH bits of the PIO word carry switch information.
  logic unused_readdata;
  assign unused_readdata = ^m_readdata[31:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // Bus outputs are forced idle while reset is high, even though the state
  // register already holds INIT. The mask write then appears only in the
  // first cycle after reset is released.
  always_comb begin
    state_next   = state;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = 2'd0;
    m_writedata  = '0;
    case (state)
      INIT: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 2'd2;
        m_writedata  = {{(32-WIDTH){1'b0}}, MASK_INIT};
        state_next   = IDLE;
      end
      IDLE: begin
        if (irq && enable) state_next = RD_CAP;
      end
      RD_CAP: begin
        m_chipselect = 1'b1;
        m_address    = 2'd3;
        state_next   = CAP_WAIT;
      end
      CAP_WAIT: begin
        state_next = (m_readdata[WIDTH-1:0] == '0) ? IDLE : CLR;
      end
      CLR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_address    = 2'd3;
        m_writedata  = 32'hFFFF_FFFF;
        state_next   = RD_DATA;
      end
      RD_DATA: begin
        m_chipselect = 1'b1;
        m_address    = 2'd0;
        state_next   = DATA_WAIT;
      end
      DATA_WAIT: state_next = PUSH;
      PUSH:      state_next = IDLE;
      default:   state_next = INIT;
    endcase
    if (reset) begin
      m_chipselect = 1'b0;
      m_write_n    = 1'b1;
      m_address    = 2'd0;
      m_writedata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap <= '0;
      lvl <= '0;
    end else begin
      if (state == CAP_WAIT)  cap <= m_readdata[WIDTH-1:0];
      if (state == DATA_WAIT) lvl <= m_readdata[WIDTH-1:0];
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign ev_valid = !empty && !reset;
  assign pop      = ev_valid && ev_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push     = (state == PUSH) && (!full || pop);
  assign drop     = (state == PUSH) && !push;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_edges[wr_ptr] <= cap;
      fifo_level[wr_ptr] <= lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign ev_edges = ev_valid ? fifo_edges[rd_ptr] : '0;
  assign ev_level = ev_valid ? fifo_level[rd_ptr] : '0;

  // A drop takes priority over a simultaneous clear request.
  always_ff @(posedge clk) begin
    if (reset)                overflow <= 1'b0;
    else if (drop)            overflow <= 1'b1;
    else if (ev_overflow_clr) overflow <= 1'b0;
  end

  assign ev_overflow = overflow && !reset;

endmodule
